// File: rtl/freq_analysis_pkg.sv
// freq_analysis_pkg: shared widths, bin word type and FSM states for the spectrum peak finder
package freq_analysis_pkg;
    localparam int DATA_W = 16;
    localparam int N_BINS = 16;
    localparam int IDX_W  = 4;
    localparam int POW_W  = 32;
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;
    typedef cplx_t frame_t [N_BINS];
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/freq_analysis_if.sv
// freq_analysis_if: spectrum frame in (fft_valid, fft_d[0..15]), result out (done, freq, overrun)
interface freq_analysis_if;
    import freq_analysis_pkg::*;
    logic             fft_valid;
    cplx_t            fft_d [N_BINS];
    logic             done;
    logic [IDX_W-1:0] freq;
    logic             overrun;
    modport master (output fft_valid, fft_d, input done, freq, overrun);
    modport slave  (input fft_valid, fft_d, output done, freq, overrun);
endinterface

// File: rtl/freq_analysis_bin_power.sv
// bin_power: combinational re^2 + im^2 of one bin (bin_i in, unsigned pow_o out)
module bin_power
    import freq_analysis_pkg::*;
(
    input  cplx_t            bin_i,
    output logic [POW_W-1:0] pow_o
);
    logic signed [POW_W-1:0] re_sq, im_sq;
    always_comb begin
        re_sq = POW_W'(bin_i.re) * POW_W'(bin_i.re);
        im_sq = POW_W'(bin_i.im) * POW_W'(bin_i.im);
        pow_o = $unsigned(re_sq) + $unsigned(im_sq);
    end
endmodule

// File: rtl/freq_analysis.sv
// freq_analysis: scans a 16-bin frame one bin per cycle and reports the strongest bin index
// Ports: clk, rst (sync, active-high); fa_if.slave carries fft_valid/fft_d in and done/freq/overrun out
module freq_analysis
    import freq_analysis_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    freq_analysis_if.slave  fa_if
);
    state_t           state_q, state_d;
    cplx_t            work_q [N_BINS];
    cplx_t            pend_q [N_BINS];
    logic             pend_full_q, pend_full_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W-1:0] freq_q, freq_d;
    logic [POW_W-1:0] max_pow_q, max_pow_d;
    logic [POW_W-1:0] pow;
    logic             overrun_q, overrun_d;
    logic             load_work, load_pend, move_pend;

    bin_power u_pow (.bin_i(work_q[idx_q]), .pow_o(pow));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        max_pow_d   = max_pow_q;
        max_idx_d   = max_idx_q;
        freq_d      = freq_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        load_work   = 1'b0;
        load_pend   = 1'b0;
        move_pend   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fa_if.fft_valid) begin
                    load_work = 1'b1;
                    state_d   = SCAN;
                    idx_d     = '0;
                    max_pow_d = '0;
                    max_idx_d = '0;
                end
            end
            SCAN: begin
                // strict compare keeps the lowest index on ties
                if (idx_q == '0 || pow > max_pow_q) begin
                    max_pow_d = pow;
                    max_idx_d = idx_q;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(N_BINS - 1)) begin
                    state_d = DONE;
                    freq_d  = max_idx_d;
                end
                if (fa_if.fft_valid) begin
                    if (pend_full_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        load_pend   = 1'b1;
                        pend_full_d = 1'b1;
                    end
                end
            end
            DONE: begin
                idx_d     = '0;
                max_pow_d = '0;
                max_idx_d = '0;
                // pending drains into work this cycle, so a new strobe can refill it without loss
                if (pend_full_q) begin
                    move_pend   = 1'b1;
                    load_pend   = fa_if.fft_valid;
                    pend_full_d = fa_if.fft_valid;
                    state_d     = SCAN;
                end else if (fa_if.fft_valid) begin
                    load_work = 1'b1;
                    state_d   = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            max_pow_q   <= '0;
            max_idx_q   <= '0;
            freq_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            max_pow_q   <= max_pow_d;
            max_idx_q   <= max_idx_d;
            freq_q      <= freq_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
        end
    end

    // frame storage needs no reset; the valid flags above gate its use
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BINS; i++) begin
            if (load_work) work_q[i] <= fa_if.fft_d[i];
            else if (move_pend) work_q[i] <= pend_q[i];
            if (load_pend) pend_q[i] <= fa_if.fft_d[i];
        end
    end

    assign fa_if.done    = (state_q == DONE);
    assign fa_if.freq    = freq_q;
    assign fa_if.overrun = overrun_q;
endmodule

// File: tb/tb_freq_analysis.sv
// tb_freq_analysis: directed checks of latency, peak selection, pending buffer, overrun and reset
module tb_freq_analysis;
    import freq_analysis_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    freq_analysis_if fa_if ();
    freq_analysis dut (.clk(clk), .rst(rst), .fa_if(fa_if));

    always #5 clk = ~clk;

    function automatic cplx_t cx(input int re, input int im);
        return '{re: 16'(re), im: 16'(im)};
    endfunction

    function automatic frame_t tone(input int k, input cplx_t pk, input cplx_t bg);
        frame_t f;
        for (int i = 0; i < N_BINS; i++) f[i] = (i == k) ? pk : bg;
        return f;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        fa_if.fft_valid = 1'b1;
        fa_if.fft_d = tone(5, cx(1000, 0), cx(0, 0));
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (fa_if.done !== 1'b0 || fa_if.freq !== 4'd0 || fa_if.overrun !== 1'b0) begin
                bad++;
                $display("FAIL reset_vals c=%0d got done=%b freq=%0d ovr=%b exp 0/0/0", c, fa_if.done, fa_if.freq, fa_if.overrun);
            end
            next_cycle();
        end
        rst = 1'b0;
        fa_if.fft_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if (fa_if.done !== 1'b0) begin
                bad++;
                $display("FAIL reset_ignore c=%0d got done=%b exp 0", c, fa_if.done);
            end
            next_cycle();
        end
    endtask

    task automatic test_spectra();
        frame_t     f [4];
        logic [3:0] ef [4];
        string      nm [4];
        f[0] = tone(5, cx(1000, 0), cx(0, 0));             ef[0] = 4'd5;  nm[0] = "single";
        f[1] = tone(3, cx(300, -400), cx(10, 10));
        f[1][12] = cx(300, -400);                          ef[1] = 4'd3;  nm[1] = "tie";
        f[2] = tone(15, cx(-32768, -32768), cx(32767, 32767)); ef[2] = 4'd15; nm[2] = "extremes";
        f[3] = tone(0, cx(0, 0), cx(0, 0));                ef[3] = 4'd0;  nm[3] = "zero";
        for (int s = 0; s < 4; s++) begin
            fa_if.fft_d = f[s];
            fa_if.fft_valid = 1'b1;
            for (int c = 0; c <= 18; c++) begin
                @(negedge clk);
                total++;
                if (fa_if.done !== (c == 17)) begin
                    bad++;
                    $display("FAIL %s_done c=%0d got=%b exp=%b", nm[s], c, fa_if.done, (c == 17));
                end
                if (c == 17) begin
                    total++;
                    if (fa_if.freq !== ef[s]) begin
                        bad++;
                        $display("FAIL %s_freq got=%0d exp=%0d", nm[s], fa_if.freq, ef[s]);
                    end
                end
                next_cycle();
                fa_if.fft_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ef;
        for (int c = 0; c <= 40; c++) begin
            fa_if.fft_valid = (c == 0 || c == 4 || c == 8);
            fa_if.fft_d = tone(c == 0 ? 2 : c == 4 ? 9 : 14, cx(1000, 0), cx(0, 0));
            @(negedge clk);
            total++;
            if (fa_if.done !== (c == 17 || c == 34)) begin
                bad++;
                $display("FAIL b2b_done c=%0d got=%b exp=%b", c, fa_if.done, (c == 17 || c == 34));
            end
            total++;
            if (fa_if.overrun !== (c >= 9)) begin
                bad++;
                $display("FAIL b2b_overrun c=%0d got=%b exp=%b", c, fa_if.overrun, (c >= 9));
            end
            if (c >= 17) begin
                ef = (c >= 34) ? 4'd9 : 4'd2;
                total++;
                if (fa_if.freq !== ef) begin
                    bad++;
                    $display("FAIL b2b_freq c=%0d got=%0d exp=%0d", c, fa_if.freq, ef);
                end
            end
            next_cycle();
        end
        fa_if.fft_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (fa_if.overrun !== 1'b0 || fa_if.freq !== 4'd0) begin
            bad++;
            $display("FAIL b2b_rst_clear got ovr=%b freq=%0d exp 0/0", fa_if.overrun, fa_if.freq);
        end
        next_cycle();
    endtask

    task automatic test_done_collision();
        logic [3:0] ef;
        logic       dexp;
        for (int c = 0; c <= 70; c++) begin
            fa_if.fft_valid = (c == 0 || c == 4 || c == 17 || c == 51);
            fa_if.fft_d = tone(c == 0 ? 1 : c == 4 ? 6 : c == 17 ? 11 : 4, cx(-700, 200), cx(5, -5));
            @(negedge clk);
            dexp = (c == 17 || c == 34 || c == 51 || c == 68);
            total++;
            if (fa_if.done !== dexp) begin
                bad++;
                $display("FAIL coll_done c=%0d got=%b exp=%b", c, fa_if.done, dexp);
            end
            total++;
            if (fa_if.overrun !== 1'b0) begin
                bad++;
                $display("FAIL coll_overrun c=%0d got=%b exp=0", c, fa_if.overrun);
            end
            if (c >= 17) begin
                ef = (c >= 68) ? 4'd4 : (c >= 51) ? 4'd11 : (c >= 34) ? 4'd6 : 4'd1;
                total++;
                if (fa_if.freq !== ef) begin
                    bad++;
                    $display("FAIL coll_freq c=%0d got=%0d exp=%0d", c, fa_if.freq, ef);
                end
            end
            next_cycle();
        end
        fa_if.fft_valid = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] ef;
        for (int c = 0; c <= 30; c++) begin
            fa_if.fft_valid = (c == 0 || c == 10);
            fa_if.fft_d = tone(c == 0 ? 7 : 13, cx(0, 900), cx(1, 1));
            rst = (c == 8);
            @(negedge clk);
            total++;
            if (fa_if.done !== (c == 27)) begin
                bad++;
                $display("FAIL rstmid_done c=%0d got=%b exp=%b", c, fa_if.done, (c == 27));
            end
            ef = (c >= 27) ? 4'd13 : (c >= 9) ? 4'd0 : 4'd4;
            total++;
            if (fa_if.freq !== ef || fa_if.overrun !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_out c=%0d got freq=%0d ovr=%b exp freq=%0d ovr=0", c, fa_if.freq, fa_if.overrun, ef);
            end
            next_cycle();
        end
        rst = 1'b0;
        fa_if.fft_valid = 1'b0;
    endtask

    initial begin
        fa_if.fft_valid = 1'b0;
        fa_if.fft_d = tone(0, cx(0, 0), cx(0, 0));
        #1;
        test_reset();
        test_spectra();
        test_back_to_back();
        test_done_collision();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/freq_analysis.md
# freq_analysis

Downstream consumer of the 16-point FFT stage in the frequency analysis system. It captures each 16-bin spectrum frame presented with `fft_valid`, computes the power re²+im² of each bin sequentially (one bin per cycle), and reports the index of the strongest bin. The result is flagged by a single-cycle `done` pulse. A one-frame pending buffer absorbs a frame that arrives while a scan is in progress.

## Interface
- `DATA_W`, 16: width of each real/imag half of a bin word. Each word is `{re[2*DATA_W-1:DATA_W], im[DATA_W-1:0]}`, two's complement.
- `N_BINS`, 16: bins per frame. Fixed at 16; `freq` is log2(N_BINS) bits.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `fft_valid`  in  1  frame strobe; all 16 `fft_d*` words are valid in this cycle.
- `fft_d0`..`fft_d15`  in  32 each  spectrum bins 0..15, in natural order.
- `done`  out  1  one-cycle pulse; `freq` is valid in this cycle.
- `freq`  out  4  index of the maximum-power bin; held until the next `done`.
- `overrun`  out  1  sticky; set when a frame is dropped. Cleared only by `RST`.

## Operation
- **State machine: IDLE, SCAN, DONE.**
- **IDLE**
  - On `fft_valid`, load the frame into the work buffer, set idx=0, clear max_pow=0 and max_idx=0, and go to SCAN.
- **SCAN**
  - Each cycle, compute pow = re[idx]² + im[idx]² as a 32-bit unsigned value. Each square is at most 2³⁰, so the sum is at most 2³¹; no overflow and no truncation.
  - If pow > max_pow (strict), or idx==0, update max_pow and max_idx.
  - Increment idx. After idx 15 is processed, go to DONE.
- **DONE**
  - Assert `done`; `freq` = max_idx.
  - Next state:
    - if the pending buffer is full, move pending into the work buffer, clear pending, and go to SCAN with idx=0;
    - else if `fft_valid` is high this cycle, load the frame directly and go to SCAN;
    - else go to IDLE.
- **Ties:** strict compare, so the lowest index among equal maxima wins. An all-zero frame gives `freq`=0.
- **`fft_valid` during SCAN**
  - If pending is empty, store the frame in pending.
  - If pending is full, drop the new frame and set `overrun`. Pending keeps the older frame.
- **`fft_valid` during DONE while pending is full:** the pending frame is scanned next. The new frame goes into pending; pending was freed in the same cycle, so there is no overrun.
- **`RST`** (any state, including mid-scan):
  - state goes to IDLE; pending is cleared;
  - `done`=0, `freq`=0, `overrun`=0;
  - max_pow, max_idx and idx go to 0.
  - The partial scan is discarded. `fft_valid` in the reset cycle is ignored.

## Timing
- Let `fft_valid` be sampled high in cycle t while in IDLE.
  - SCAN occupies cycles t+1..t+16 (bin k in cycle t+1+k).
  - `done` is high in cycle t+17.
- Latency is 17 cycles from strobe to `done`. `done` is high for exactly one cycle.
- Back-to-back frames taken from pending: the second scan starts in cycle t+18, so its `done` comes at t+34. The minimum interval between `done` pulses is 17 cycles.
- `freq` changes only in a `done` cycle. It is registered and glitch-free.
- `overrun` rises in the cycle after the dropped strobe and stays high until `RST`.
- Reset values: `done`=0, `freq`=0, `overrun`=0.

## Structure
- **Shared package `freq_analysis_pkg`:**
  - `DATA_W`, `N_BINS`, `IDX_W`=4, `POW_W`=32;
  - packed `cplx_t` typedef {re, im};
  - state enum {IDLE, SCAN, DONE}.
  - The upstream FFT stage reuses `cplx_t`.
- **Sub-module `bin_power`:** combinational; `cplx_t` in, `POW_W` unsigned power out. Uses signed 16×16 squares. One instance is muxed by idx.
- The top level holds the FSM, the work and pending buffers (16×32 bits each), and the compare/max registers.

## Test plan
- **Single tone:** bin 5 = {1000, 0}, all other bins 0 → `done` 17 cycles after the strobe, `freq`=5.
- **Tie:** bins 3 and 12 both {300, -400} (power 250000), others {10, 10} → `freq`=3.
- **Extremes:** bin 15 = {-32768, -32768} (power 2³¹), bins 0..14 = {32767, 32767} → `freq`=15, with no wrap of the power value.
- **Zero frame:** all bins 0 → `freq`=0.
- **Back-to-back frames:** three frames with peaks at 2, 9 and 14; the second strobe at t+4, the third at t+8 (pending already full) → `done` at t+17 with `freq`=2, `done` at t+34 with `freq`=9, `overrun`=1 from t+9, and no third `done`.
- **Reset mid-scan:** `RST` at t+8 → no `done`, all outputs 0. A new strobe at t+10 gives `done` at t+27 with the correct `freq`.
